scan_controller: RTL and testbench
==================================

# scan_controller

Sequencing controller for the 3-digit dynamic-scan seven-segment display. It owns the mod-4 scan counter that drives the digit selector's `SEL` input. It also holds the frame value presented on the selector's 10-bit `Data` input and drives the one-hot digit enables. New values are accepted through a load/acknowledge handshake and applied only at frame boundaries, so a frame never shows digits from two different values. It also produces the leading-zero blank indication for the segment driver.

## Interface
- `DIV`, default 50000: clock cycles per digit slot (legal range ≥ 2).
- `CLK`  input  1  system clock; all state changes on rising edge.
- `RST_n`  input  1  reset; one clock, reset is asynchronous and active-low.
- `LOAD`  input  1  single-cycle strobe: capture `DIN` as the next display value.
- `DIN`  input  10  value to display, unsigned.
- `SEL`  output  2  scan counter value, to the digit selector (0 = units, 1 = tens, 2 = hundreds, 3 = dead slot).
- `DATA`  output  10  frame value, to the digit selector `Data` input; always ≤ 999.
- `DIG_EN`  output  3  one-hot digit enable, active-high, bit i = digit i; all-zero in the dead slot.
- `BLANK`  output  1  current digit is a leading zero and must be blanked.
- `BUSY`  output  1  a loaded value is pending, waiting for the frame boundary.
- `ACK`  output  1  one-cycle pulse: a pending value has been applied to `DATA`.
- `OVF`  output  1  sticky: some applied value exceeded 999 and was clamped.

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps. `tick` = (`cnt` == DIV-1).
- On `tick`, `SEL` advances 0→1→2→3→0. Slot 3 is a dead slot that prevents ghosting. The selector outputs 0 there, and `DIG_EN` is 3'b000.
- `DIG_EN` is registered and updates on the same edge as `SEL`: 3'b001, 3'b010, 3'b100, 3'b000 for `SEL` 0, 1, 2, 3.
- Frame boundary = the `tick` edge on which `SEL` goes 3→0.
- `LOAD` handling:
  - Captures `DIN` into the pending register and sets `BUSY`.
  - A further `LOAD` while `BUSY` overwrites the pending value (latest wins). Only one `ACK` is issued per application.
- At the frame boundary, if a value is pending:
  - `DATA` ← min(pending, 999).
  - `OVF` is set if pending > 999.
  - `BUSY` is cleared.
  - `ACK` is high for exactly the next cycle.
- Simultaneous `LOAD` and frame boundary in the same cycle: the `LOAD` value (`DIN`) is applied directly at that edge, replacing any older pending value. `BUSY` remains 0 afterwards, and `ACK` is pulsed.
- No pending value at a boundary: `DATA` holds and `ACK` stays 0.
- `BLANK` is a registered output, computed from next `SEL` and next `DATA`:
  - 1 when `SEL` = 2 and `DATA` < 100.
  - 1 when `SEL` = 1 and `DATA` < 10.
  - 0 for `SEL` = 0, so value 0 still shows a single "0".
  - 1 when `SEL` = 3.
- `OVF` clears only on reset.

## Timing
- Reset values:
  - `cnt` = 0, `SEL` = 0, `DIG_EN` = 3'b001.
  - `DATA` = 0, `BLANK` = 0.
  - `BUSY` = 0, `ACK` = 0, `OVF` = 0, pending register = 0.
- Reset asserted mid-frame or while `BUSY`: immediately returns to the reset values. The pending value is discarded and no `ACK` is issued.
- Slot length is exactly DIV cycles. A frame is 4·DIV cycles; the first frame after reset starts at the first edge after `RST_n` deasserts.
- `BUSY` rises the cycle after `LOAD`.
- Load-to-`ACK` latency:
  - Minimum 1 cycle (`LOAD` on the boundary cycle).
  - Maximum 4·DIV cycles.
- `DATA`, `SEL`, `DIG_EN` and `BLANK` change only on `tick` edges. At a frame boundary all four change on the same edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, DIV=4: hold `RST_n`=0, then release. Checks:
  - `SEL`=0, `DIG_EN`=001, `DATA`=0, `BUSY`/`ACK`/`OVF`=0.
  - `SEL` steps 0,1,2,3,0 every 4 cycles.
  - `DIG_EN` steps 001,010,100,000.
- Load mid-frame, DIV=4: `LOAD` with `DIN`=472 while `SEL`=1. Checks:
  - `BUSY`=1 the next cycle.
  - At the 3→0 boundary, `DATA`=472 and `ACK` is one cycle high.
  - `BLANK` stays 0 in slots 0–2.
- Leading-zero blanking: apply 7, then 35, then 0. Required `BLANK` in slots 0/1/2/3:
  - 7 → 0/1/1/1.
  - 35 → 0/0/1/1.
  - 0 → 0/1/1/1.
- Latest-wins and boundary collision:
  - Two `LOAD`s (100, then 250) within one frame → a single `ACK`, `DATA`=250.
  - `LOAD` of 9 exactly on the boundary cycle → `DATA`=9 at that edge, `ACK` the next cycle, `BUSY` never rises.
- Clamp: `LOAD` with `DIN`=1023 → `DATA`=999 and `OVF`=1. A later `LOAD` of 5 leaves `OVF`=1.
- Reset mid-operation: `LOAD` 321, then assert `RST_n`=0 before the boundary. Checks: all outputs return to reset values at once, and `ACK` never pulses.

Source files
------------

// File: rtl/scan_controller_if.sv
// Display-side bus of the scan controller: load handshake in, scan/frame state out.
// Signals are plain wires. Timing is owned by scan_controller, and every output is registered there.
interface scan_controller_if;
  logic       LOAD;
  logic [9:0] DIN;
  logic [1:0] SEL;
  logic [9:0] DATA;
  logic [2:0] DIG_EN;
  logic       BLANK;
  logic       BUSY;
  logic       ACK;
  logic       OVF;

  modport master (
    output LOAD, DIN,
    input  SEL, DATA, DIG_EN, BLANK, BUSY, ACK, OVF
  );

  modport slave (
    input  LOAD, DIN,
    output SEL, DATA, DIG_EN, BLANK, BUSY, ACK, OVF
  );
endinterface

// File: rtl/scan_controller.sv
// 3-digit scan sequencer: a mod-4 digit slot of DIV cycles, with frame-aligned value updates and leading-zero blanking.
// Registered outputs. A load is applied at the next 3->0 boundary (1..4*DIV cycles later), and LOAD is never refused.
module scan_controller #(
  parameter int DIV = 50000
) (
  input  logic          CLK,
  input  logic          RST_n,
  scan_controller_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [9:0] MAXV = 10'd999;

  logic [CW-1:0] cnt;
  logic [9:0]    pend;

  logic          tick;
  logic          boundary;
  logic          do_apply;
  logic [9:0]    apply_src;
  logic [1:0]    sel_n;
  logic [9:0]    data_n;
  logic [2:0]    en_n;
  logic          blank_n;

  always_comb begin
    tick      = (cnt == CW'(DIV - 1));
    boundary  = tick && (bus.SEL == 2'd3);
    // A LOAD arriving on the boundary cycle bypasses the pending register.
    apply_src = bus.LOAD ? bus.DIN : pend;
    do_apply  = boundary && (bus.LOAD || bus.BUSY);
    sel_n     = tick ? bus.SEL + 2'd1 : bus.SEL;
    data_n    = bus.DATA;
    if (do_apply) data_n = (apply_src > MAXV) ? MAXV : apply_src;

    en_n = 3'b000;
    case (sel_n)
      2'd0:    en_n = 3'b001;
      2'd1:    en_n = 3'b010;
      2'd2:    en_n = 3'b100;
      default: en_n = 3'b000;
    endcase

    blank_n = 1'b0;
    case (sel_n)
      2'd1:    blank_n = (data_n < 10'd10);
      2'd2:    blank_n = (data_n < 10'd100);
      2'd3:    blank_n = 1'b1;
      default: blank_n = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt        <= '0;
      pend       <= '0;
      bus.SEL    <= 2'd0;
      bus.DIG_EN <= 3'b001;
      bus.DATA   <= '0;
      bus.BLANK  <= 1'b0;
      bus.BUSY   <= 1'b0;
      bus.ACK    <= 1'b0;
      bus.OVF    <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      bus.SEL    <= sel_n;
      bus.DIG_EN <= en_n;
      bus.DATA   <= data_n;
      bus.BLANK  <= blank_n;
      bus.ACK    <= do_apply;
      if (bus.LOAD) pend <= bus.DIN;
      if (do_apply) begin
        bus.BUSY <= 1'b0;
        if (apply_src > MAXV) bus.OVF <= 1'b1;
      end else if (bus.LOAD) begin
        bus.BUSY <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_scan_controller.sv
// Scoreboarded bench for scan_controller. The model derives slot and frame position from the edge count since reset.
module tb_scan_controller;
  localparam int DIV = 4;
  localparam int FR  = 4 * DIV;

  logic CLK   = 1'b0;
  logic RST_n = 1'b0;

  scan_controller_if bus();

  scan_controller #(.DIV(DIV)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int data;
    bit ovf;
  } ack_t;

  ack_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  // Model state, meaning the values expected after the most recent edge.
  int   m_e;
  int   m_data;
  int   m_pend;
  bit   m_busy;
  bit   m_ovf;
  bit   m_ld;
  int   m_din;
  int   m_v;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      m_e = 0; m_data = 0; m_pend = 0; m_busy = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      m_ld  = bus.LOAD;
      m_din = int'(bus.DIN);
      m_e++;
      if ((m_e % FR == 0) && (m_ld || m_busy)) begin
        m_v    = m_ld ? m_din : m_pend;
        m_ovf  = m_ovf || (m_v > 999);
        m_data = (m_v > 999) ? 999 : m_v;
        m_busy = 0;
        exp_q.push_back('{m_data, m_ovf});
      end else if (m_ld) begin
        m_pend = m_din;
        m_busy = 1;
      end
    end
  end

  int   s_exp;
  int   en_exp;
  bit   bl_exp;
  ack_t a_exp;

  always @(negedge CLK) begin
    if (chk_en) begin
      s_exp  = (m_e / DIV) % 4;
      en_exp = (s_exp == 3) ? 0 : (1 << s_exp);
      bl_exp = (s_exp == 3) || (s_exp == 2 && m_data < 100) || (s_exp == 1 && m_data < 10);
      chk("sel",    32'(bus.SEL),    s_exp);
      chk("dig_en", 32'(bus.DIG_EN), en_exp);
      chk("data",   32'(bus.DATA),   m_data);
      chk("blank",  32'(bus.BLANK),  32'(bl_exp));
      chk("busy",   32'(bus.BUSY),   32'(m_busy));
      chk("ovf",    32'(bus.OVF),    32'(m_ovf));
      if (bus.ACK === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("ack_spurious", 32'(bus.ACK), 0);
        end else begin
          a_exp = exp_q.pop_front();
          chk("ack_data", 32'(bus.DATA), a_exp.data);
          chk("ack_ovf",  32'(bus.OVF),  32'(a_exp.ovf));
        end
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        chk("ack_missing", 32'(bus.ACK), 1);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic load(input int v);
    logic [31:0] vv;
    vv       = v;
    bus.LOAD = 1'b1;
    bus.DIN  = vv[9:0];
    cyc(1);
    bus.LOAD = 1'b0;
  endtask

  task automatic wait_pos(input int r);
    int guard;
    guard = 0;
    while ((m_e % FR) != r && guard < 2 * FR) begin
      cyc(1);
      guard++;
    end
    if ((m_e % FR) != r) begin
      tests++;
      fails++;
      $display("FAIL wait_pos: frame position %0d, wanted %0d", m_e % FR, r);
    end
  endtask

  initial begin
    int vals[3];
    int v;
    vals = '{7, 35, 0};
    bus.LOAD = 1'b0;
    bus.DIN  = '0;
    RST_n    = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    cyc(2);
    RST_n = 1'b1;
    cyc(2 * FR);

    wait_pos(5);            // LOAD is sampled while SEL = 1
    load(472);
    cyc(2 * FR);

    foreach (vals[i]) begin
      wait_pos(2);
      load(vals[i]);
      cyc(2 * FR);
    end

    wait_pos(1);
    load(100);
    cyc(3);
    load(250);
    cyc(2 * FR);

    wait_pos(FR - 1);       // LOAD lands on the boundary edge itself
    load(9);
    cyc(FR);

    wait_pos(3);
    load(1023);
    cyc(2 * FR);
    wait_pos(3);
    load(5);
    cyc(2 * FR);

    wait_pos(2);
    load(321);
    cyc(3);
    RST_n = 1'b0;
    cyc(2);
    RST_n = 1'b1;
    cyc(FR);

    repeat (600) begin
      if ($urandom_range(0, 299) == 0) begin
        RST_n = 1'b0;
        cyc(1);
        RST_n = 1'b1;
      end else if ($urandom_range(0, 7) == 0) begin
        v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023))
                                        : int'($urandom_range(0, 1023));
        load(v);
      end else begin
        cyc(1);
      end
    end
    cyc(2 * FR);

    chk_en = 1'b0;
    chk("ack_queue_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
